// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scanner with press and release debounce.
// Drives one column low at a time (one-cold), samples the synchronised rows
// on the last dwell cycle of each column, debounces the lowest-index low row
// and emits one registered key code with a single-cycle key_valid per press.
//
// Latency: for a press that is stable before the sampling cycle, key_valid
// is high exactly DEBOUNCE_CYCLES + 1 cycles after the sampling cycle. The
// two synchroniser cycles are absorbed inside the column dwell, so this is
// the "2 + DEBOUNCE_CYCLES" figure minus one.
//
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid every
// REPEAT_CYCLES while the accepted key stays held. Without the macro the
// repeat logic is absent and exactly one key_valid is produced per press.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 100000,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int REPEAT_CYCLES   = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DWELL_W = $clog2(SCAN_CYCLES) + 1;
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

  // The sample point must land after the 2-flop synchroniser has seen the new column.
  if (SCAN_CYCLES < 3 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("keypad_scanner: cycle parameters out of range");
  end

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [3:0]         rows_meta_r, rows_sync_r;
  logic [1:0]         col_idx_r, col_idx_nxt_s;
  logic [1:0]         row_idx_r, row_idx_nxt_s;
  logic [DWELL_W-1:0] dwell_cnt_r, dwell_cnt_nxt_s;
  logic [DEB_W-1:0]   deb_cnt_r, deb_cnt_nxt_s;
  logic [3:0]         cols_r, cols_nxt_s;
  logic [3:0]         key_code_r, key_code_nxt_s;
  logic               key_valid_r, key_valid_nxt_s;
  logic               key_down_r, key_down_nxt_s;
  logic               row_low_s;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0]   rep_cnt_r, rep_cnt_nxt_s;
`endif

  // Keypad layout: (row, col) to hex code.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  // Lowest-index row that reads low; rows are active-low.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] r);
    logic [1:0] idx;
    if (!r[0])      idx = 2'd0;
    else if (!r[1]) idx = 2'd1;
    else if (!r[2]) idx = 2'd2;
    else if (!r[3]) idx = 2'd3;
    else            idx = 2'd0;
    return idx;
  endfunction

  assign row_low_s = ~rows_sync_r[row_idx_r];

  // Two-flop synchroniser for the asynchronous row inputs (idle high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_meta_r <= 4'hF;
      rows_sync_r <= 4'hF;
    end else begin
      rows_meta_r <= rows;
      rows_sync_r <= rows_meta_r;
    end
  end

  // Next-state and next-output logic for the SCAN / DEBOUNCE / HELD machine.
  always_comb begin
    state_nxt_s     = state_r;
    col_idx_nxt_s   = col_idx_r;
    row_idx_nxt_s   = row_idx_r;
    dwell_cnt_nxt_s = dwell_cnt_r;
    deb_cnt_nxt_s   = deb_cnt_r;
    key_code_nxt_s  = key_code_r;
    key_valid_nxt_s = 1'b0;
    key_down_nxt_s  = key_down_r;
    cols_nxt_s      = cols_r;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_nxt_s   = rep_cnt_r;
`endif

    case (state_r)
      ST_SCAN: begin
        if (dwell_cnt_r == DWELL_LAST) begin
          dwell_cnt_nxt_s = {DWELL_W{1'b0}};
          if (rows_sync_r != 4'hF) begin
            // Column stays driven; remember which row to debounce.
            row_idx_nxt_s = lowest_low_row(rows_sync_r);
            deb_cnt_nxt_s = {DEB_W{1'b0}};
            state_nxt_s   = ST_DEBOUNCE;
          end else begin
            col_idx_nxt_s = col_idx_r + 2'd1;
          end
        end else begin
          dwell_cnt_nxt_s = dwell_cnt_r + DWELL_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (row_low_s) begin
          if (deb_cnt_r == DEB_LAST) begin
            key_code_nxt_s  = key_map(row_idx_r, col_idx_r);
            key_valid_nxt_s = 1'b1;
            key_down_nxt_s  = 1'b1;
            deb_cnt_nxt_s   = {DEB_W{1'b0}};
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_nxt_s   = {REP_W{1'b0}};
`endif
            state_nxt_s     = ST_HELD;
          end else begin
            deb_cnt_nxt_s = deb_cnt_r + DEB_W'(1);
          end
        end else begin
          // Bounce: rescan the same column from the start of its dwell.
          dwell_cnt_nxt_s = {DWELL_W{1'b0}};
          deb_cnt_nxt_s   = {DEB_W{1'b0}};
          state_nxt_s     = ST_SCAN;
        end
      end

      ST_HELD: begin
        if (!row_low_s) begin
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_cnt_nxt_s = {REP_W{1'b0}};
`endif
          if (deb_cnt_r == DEB_LAST) begin
            key_down_nxt_s  = 1'b0;
            col_idx_nxt_s   = col_idx_r + 2'd1;
            dwell_cnt_nxt_s = {DWELL_W{1'b0}};
            deb_cnt_nxt_s   = {DEB_W{1'b0}};
            state_nxt_s     = ST_SCAN;
          end else begin
            deb_cnt_nxt_s = deb_cnt_r + DEB_W'(1);
          end
        end else begin
          deb_cnt_nxt_s = {DEB_W{1'b0}};
`ifdef KEYPAD_AUTOREPEAT_EN
          if (rep_cnt_r == REP_LAST) begin
            rep_cnt_nxt_s   = {REP_W{1'b0}};
            key_valid_nxt_s = 1'b1;
          end else begin
            rep_cnt_nxt_s = rep_cnt_r + REP_W'(1);
          end
`endif
        end
      end

      default: begin
        state_nxt_s     = ST_SCAN;
        col_idx_nxt_s   = 2'd0;
        dwell_cnt_nxt_s = {DWELL_W{1'b0}};
        deb_cnt_nxt_s   = {DEB_W{1'b0}};
        key_down_nxt_s  = 1'b0;
      end
    endcase

    cols_nxt_s = ~(4'b0001 << col_idx_nxt_s);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_SCAN;
      col_idx_r   <= 2'd0;
      row_idx_r   <= 2'd0;
      dwell_cnt_r <= {DWELL_W{1'b0}};
      deb_cnt_r   <= {DEB_W{1'b0}};
      cols_r      <= 4'b1110;
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
      key_down_r  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_r   <= {REP_W{1'b0}};
`endif
    end else begin
      state_r     <= state_nxt_s;
      col_idx_r   <= col_idx_nxt_s;
      row_idx_r   <= row_idx_nxt_s;
      dwell_cnt_r <= dwell_cnt_nxt_s;
      deb_cnt_r   <= deb_cnt_nxt_s;
      cols_r      <= cols_nxt_s;
      key_code_r  <= key_code_nxt_s;
      key_valid_r <= key_valid_nxt_s;
      key_down_r  <= key_down_nxt_s;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_r   <= rep_cnt_nxt_s;
`endif
    end
  end

  assign cols      = cols_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_down  = key_down_r;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the game logic: drives the 4x4 Pmod keypad columns, samples the rows, debounces press and release, and emits one registered hex key code per physical press.
- Outputs feed the game block's dec and button_pressed inputs.
- A press produces exactly one key_valid pulse; there is no repeat unless the optional feature is compiled in.

Parameters:
- SCAN_CYCLES, 100000, clk cycles each column is driven before rows are sampled (1 ms at 100 MHz).
- DEBOUNCE_CYCLES, 2000000, consecutive stable cycles required to accept a press or a release (20 ms).
- REPEAT_CYCLES, 50000000, hold time between auto-repeat pulses; used only with the optional feature.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- rows  input  4  keypad rows, pulled up; low = key pressed; rows[0] = top row.
- cols  output  4  keypad column drive, one-cold; cols[0] = leftmost column.
- key_code  output  4  code of last accepted key; held until the next accept.
- key_valid  output  1  one-cycle pulse when key_code is updated.
- key_down  output  1  high while an accepted key is still held (HELD state).

Behaviour:
- Reset values: cols=4'b1110, col_idx=0, state=SCAN, key_code=0, key_valid=0, key_down=0, all counters=0.
- Input synchronisation: rows pass through 2 flops (rows_s); all decisions use rows_s. Reset value of both flops is 4'hF.
- Key map, (row,col)->code:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: 0,F,E,D
- Column drive: cols = ~(4'b0001 << col_idx), always registered.
- SCAN state:
  - dwell counter counts 0..SCAN_CYCLES-1 on the current column.
  - On the last dwell cycle: if rows_s != 4'hF, capture col_idx and the lowest-index low row, clear the debounce counter, go to DEBOUNCE. The column stays driven.
  - Otherwise advance col_idx with wrap 3->0 and restart the dwell.
- DEBOUNCE state:
  - Counter increments while the captured row bit is low.
  - If that bit goes high before the count is reached: return to SCAN on the same column with the dwell restarted. No output change.
  - When the counter reaches DEBOUNCE_CYCLES: register key_code from the map, pulse key_valid for exactly 1 cycle, set key_down, go to HELD.
- HELD state:
  - The captured column stays driven.
  - Release counter increments while the captured row bit is high and clears to 0 whenever the bit is low.
  - When it reaches DEBOUNCE_CYCLES: clear key_down, advance col_idx (wrap), go to SCAN.
- Priority and other keys:
  - Multiple rows low in one column: lowest row index wins.
  - Keys in other columns are ignored until return to SCAN.
  - Other rows changing in DEBOUNCE/HELD have no effect.
- Latency: a press stable from before the dwell end gives key_valid 2 (sync) + DEBOUNCE_CYCLES cycles after the sampling cycle, within ±1 cycle fixed by implementation and documented in RTL header.
- Reset mid-operation: rst_n low forces all reset values immediately, including mid-pulse; no key_valid on deassertion even if a key is held (normal scan resumes from column 0).
- Counters: width $clog2 of the largest count + 1; no overflow possible because each counter is cleared on every state entry.

Optional Feature:
- Macro KEYPAD_AUTOREPEAT_EN.
- Defined: in HELD, a repeat counter counts while the key is held (captured row bit low). Every REPEAT_CYCLES it emits another 1-cycle key_valid with the same key_code, then restarts. It clears on any high sample of the row bit.
- Undefined: repeat logic is absent and REPEAT_CYCLES is unused; exactly one key_valid per press.

Test Plan:
Use SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=16, with a keypad model that pulls row r low while cols[c]=0 for the pressed key.
1. Reset: hold rst_n=0 with rows toggling -> cols=4'b1110, key_code=0, key_valid=0, key_down=0. After release, cols cycles 1110->1101->1011->0111->1110 with 4 cycles per column.
2. Press (row1,col2) stable for 40 cycles -> exactly one key_valid, key_code=4'h6, key_down high. Release -> key_down low 8+2 cycles later, scanning resumes at col3.
3. Bounce: press (row3,col0) for 5 cycles, release, repeat 3 times -> no key_valid. Then a stable press -> one pulse, key_code=4'h0.
4. Two keys (row0,col1) and (row2,col1) pressed together -> key_code=4'h2. Hold (row0,col3) during HELD -> ignored. Release both -> next scan captures 4'hA.
5. Reset asserted during HELD with the key still pressed -> outputs cleared at once. After deassertion the key is re-detected through full scan+debounce, with a single pulse.
6. With KEYPAD_AUTOREPEAT_EN, hold (row2,col3) for 60 cycles after accept -> 3 extra key_valid pulses 16 cycles apart, all with key_code=4'hC. Without the macro -> only the first pulse.
